// File: rtl/ventana_pkg.sv
// ---------------------------------------------------------------------------
// ventana_pkg
// Shared definitions for the window read sequencer: register address map,
// control/status bit positions and the sequencer FSM state encoding.
// ---------------------------------------------------------------------------
package ventana_pkg;

   // Register map, decoded from the low three bits of the register address
   localparam logic [2:0] DIR_INICIO   = 3'd0;
   localparam logic [2:0] DIR_LECTURAS = 3'd1;
   localparam logic [2:0] DIR_BUFFERS  = 3'd2;
   localparam logic [2:0] DIR_CONTROL  = 3'd3;
   localparam logic [2:0] DIR_ESTADO   = 3'd4;
   localparam logic [2:0] DIR_ESPERAS  = 3'd5;

   // Control register bits (write-only, self-clearing)
   localparam int BIT_INICIAR = 0;
   localparam int BIT_ABORTAR = 1;

   // Status register bits
   localparam int BIT_OCUPADO      = 0;
   localparam int BIT_ERROR_CONFIG = 1;
   localparam int BIT_ABORTADO     = 2;

   typedef enum logic [1:0] {
      REPOSO      = 2'd0,
      SOLICITANDO = 2'd1,
      FIN         = 2'd2
   } estado_t;

endpackage

// File: rtl/FlipFlopD_Habilitado.sv
// ---------------------------------------------------------------------------
// FlipFlopD_Habilitado
// Parametrised D register with load enable, used for the window
// configuration registers.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset (clears q)
//   habilitacion load enable
//   d            data in (ANCHO bits)
//   q            registered data out (ANCHO bits)
// ---------------------------------------------------------------------------
module FlipFlopD_Habilitado #(
   parameter int ANCHO = 21
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             habilitacion,
   input  logic [ANCHO-1:0] d,
   output logic [ANCHO-1:0] q
);

   // Load d when enabled, hold otherwise
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (habilitacion) begin
         q <= d;
      end
   end

endmodule

// File: rtl/contador_seleccion_buffer.sv
// ---------------------------------------------------------------------------
// contador_seleccion_buffer
// Tracks how many reads have gone to the current internal buffer and which
// buffer is the destination of the next read. After LECTURAS_POR_BUFFER
// accepted reads the selection advances, wrapping after eff_buffers-1.
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   limpiar          restart at buffer 0, read 0 (has priority over avanzar)
//   avanzar          one accepted read
//   eff_buffers      number of buffers in use (always >= 1)
//   buffer_seleccion destination buffer of the current read
// ---------------------------------------------------------------------------
module contador_seleccion_buffer #(
   parameter int BITS_BUFFERS        = 3,
   parameter int LECTURAS_POR_BUFFER = 128
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    limpiar,
   input  logic                    avanzar,
   input  logic [BITS_BUFFERS-1:0] eff_buffers,
   output logic [BITS_BUFFERS-1:0] buffer_seleccion
);

   // One bit minimum so LECTURAS_POR_BUFFER=1 still elaborates
   localparam int BITS_LECT = (LECTURAS_POR_BUFFER > 1) ? $clog2(LECTURAS_POR_BUFFER) : 1;
   localparam logic [BITS_LECT-1:0] ULTIMA_LECT = BITS_LECT'(LECTURAS_POR_BUFFER - 1);

   logic [BITS_LECT-1:0] lecturas_buffer;

   // Per-buffer read count and buffer selection, both wrapping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lecturas_buffer  <= '0;
         buffer_seleccion <= '0;
      end else if (limpiar) begin
         lecturas_buffer  <= '0;
         buffer_seleccion <= '0;
      end else if (avanzar) begin
         if (lecturas_buffer == ULTIMA_LECT) begin
            lecturas_buffer <= '0;
            if (buffer_seleccion == eff_buffers - 1'b1) begin
               buffer_seleccion <= '0;
            end else begin
               buffer_seleccion <= buffer_seleccion + 1'b1;
            end
         end else begin
            lecturas_buffer <= lecturas_buffer + 1'b1;
         end
      end
   end

endmodule

// File: rtl/secuenciador_lecturas_ventana.sv
// ---------------------------------------------------------------------------
// secuenciador_lecturas_ventana
// Window configuration registers plus a read sequencer. A start command
// issues a valid/ready stream of memory read addresses, each tagged with the
// destination internal buffer of the line buffer.
// Optional feature (macro SECUENCIADOR_CONTADOR_ESPERAS_EN): saturating count
// of stalled request cycles, readable at register 5.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   direccion_registros      register select (bits [2:0] decoded)
//   datos_registros          register write data
//   habilitacion_registros   one-cycle write strobe
//   lectura_registros        combinational register readback
//   mem_direccion            read address
//   mem_solicitud            read request valid
//   mem_aceptada             memory ready
//   buffer_seleccion         destination buffer of the current request
//   ocupado                  sequencer active
//   fin                      one-cycle completion pulse
// ---------------------------------------------------------------------------
module secuenciador_lecturas_ventana
   import ventana_pkg::*;
#(
   parameter int BITS_BUS_DATOS_INSTR     = 21,
   parameter int BITS_BUS_DIRECCION_INSTR = 11,
   parameter int BITS_BUFFERS             = 3,
   parameter int LECTURAS_POR_BUFFER      = 128,
   parameter int PASO_DIRECCION           = 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [BITS_BUS_DIRECCION_INSTR-1:0] direccion_registros,
   input  logic [BITS_BUS_DATOS_INSTR-1:0]     datos_registros,
   input  logic                                habilitacion_registros,
   output logic [BITS_BUS_DATOS_INSTR-1:0]     lectura_registros,
   output logic [BITS_BUS_DATOS_INSTR-1:0]     mem_direccion,
   output logic                                mem_solicitud,
   input  logic                                mem_aceptada,
   output logic [BITS_BUFFERS-1:0]             buffer_seleccion,
   output logic                                ocupado,
   output logic                                fin
);

   localparam int W = BITS_BUS_DATOS_INSTR;
   localparam logic [W-1:0] PASO_W = W'(PASO_DIRECCION);

   estado_t estado, estado_siguiente;

   logic [2:0]              dir_sel;
   logic                    en_solicitud;
   logic                    escritura_control, iniciar_cmd, abortar_cmd;
   logic                    inicio_aceptado, transferencia, ultima;
   logic                    escritura_config;
   logic                    hab_inicio, hab_lecturas, hab_buffers;
   logic [W-1:0]            direccion_inicio, cantidad_lecturas, contador;
   logic [BITS_BUFFERS-1:0] cantidad_buffers, eff_buffers;
   logic                    error_config, abortado;

   assign dir_sel           = direccion_registros[2:0];
   assign en_solicitud      = (estado == SOLICITANDO);
   assign escritura_control = habilitacion_registros && (dir_sel == DIR_CONTROL);
   assign iniciar_cmd       = escritura_control && datos_registros[BIT_INICIAR];
   assign abortar_cmd       = escritura_control && datos_registros[BIT_ABORTAR];
   // Starts are only taken from idle; abort is irrelevant there, so start wins
   assign inicio_aceptado   = iniciar_cmd && (estado == REPOSO);
   assign transferencia     = en_solicitud && mem_aceptada;
   assign ultima            = (contador == cantidad_lecturas - 1'b1);
   assign escritura_config  = habilitacion_registros &&
                              ((dir_sel == DIR_INICIO) || (dir_sel == DIR_LECTURAS) ||
                               (dir_sel == DIR_BUFFERS));
   // Configuration is frozen while a run is in progress
   assign hab_inicio   = habilitacion_registros && (dir_sel == DIR_INICIO)   && !en_solicitud;
   assign hab_lecturas = habilitacion_registros && (dir_sel == DIR_LECTURAS) && !en_solicitud;
   assign hab_buffers  = habilitacion_registros && (dir_sel == DIR_BUFFERS)  && !en_solicitud;
   assign eff_buffers  = (cantidad_buffers == '0) ? BITS_BUFFERS'(1) : cantidad_buffers;

   FlipFlopD_Habilitado #(.ANCHO(W)) reg_inicio (
      .clk(clk), .reset(reset), .habilitacion(hab_inicio),
      .d(datos_registros), .q(direccion_inicio)
   );

   FlipFlopD_Habilitado #(.ANCHO(W)) reg_lecturas (
      .clk(clk), .reset(reset), .habilitacion(hab_lecturas),
      .d(datos_registros), .q(cantidad_lecturas)
   );

   FlipFlopD_Habilitado #(.ANCHO(BITS_BUFFERS)) reg_buffers (
      .clk(clk), .reset(reset), .habilitacion(hab_buffers),
      .d(datos_registros[BITS_BUFFERS-1:0]), .q(cantidad_buffers)
   );

   contador_seleccion_buffer #(
      .BITS_BUFFERS(BITS_BUFFERS),
      .LECTURAS_POR_BUFFER(LECTURAS_POR_BUFFER)
   ) u_seleccion (
      .clk(clk), .reset(reset), .limpiar(inicio_aceptado), .avanzar(transferencia),
      .eff_buffers(eff_buffers), .buffer_seleccion(buffer_seleccion)
   );

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado <= REPOSO;
      end else begin
         estado <= estado_siguiente;
      end
   end

   // Next state; an abort beats a simultaneous final transfer
   always_comb begin
      estado_siguiente = estado;
      case (estado)
         REPOSO: begin
            if (inicio_aceptado) begin
               estado_siguiente = (cantidad_lecturas == '0) ? FIN : SOLICITANDO;
            end
         end
         SOLICITANDO: begin
            if (abortar_cmd) begin
               estado_siguiente = REPOSO;
            end else if (transferencia && ultima) begin
               estado_siguiente = FIN;
            end
         end
         FIN:     estado_siguiente = REPOSO;
         default: estado_siguiente = REPOSO;
      endcase
   end

   // FSM outputs; address wraps naturally at the bus width
   always_comb begin
      mem_solicitud = 1'b0;
      ocupado       = 1'b0;
      fin           = 1'b0;
      mem_direccion = '0;
      case (estado)
         SOLICITANDO: begin
            mem_solicitud = 1'b1;
            ocupado       = 1'b1;
            mem_direccion = direccion_inicio + contador * PASO_W;
         end
         FIN:     fin = 1'b1;
         default: ;
      endcase
   end

   // Read counter: restarted by a start, bumped by every accepted read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         contador <= '0;
      end else if (inicio_aceptado) begin
         contador <= '0;
      end else if (transferencia) begin
         contador <= contador + 1'b1;
      end
   end

   // Sticky status flags, cleared only by an accepted start
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         error_config <= 1'b0;
         abortado     <= 1'b0;
      end else if (inicio_aceptado) begin
         error_config <= 1'b0;
         abortado     <= 1'b0;
      end else begin
         if (escritura_config && en_solicitud) error_config <= 1'b1;
         if (abortar_cmd && en_solicitud)      abortado     <= 1'b1;
      end
   end

`ifdef SECUENCIADOR_CONTADOR_ESPERAS_EN
   logic [W-1:0] esperas;

   // Saturating count of cycles a request waited on the memory
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         esperas <= '0;
      end else if (inicio_aceptado) begin
         esperas <= '0;
      end else if (en_solicitud && !mem_aceptada && (esperas != '1)) begin
         esperas <= esperas + 1'b1;
      end
   end
`endif

   // Register readback
   always_comb begin
      lectura_registros = '0;
      case (dir_sel)
         DIR_INICIO:   lectura_registros = direccion_inicio;
         DIR_LECTURAS: lectura_registros = cantidad_lecturas;
         DIR_BUFFERS:  lectura_registros = {{(W-BITS_BUFFERS){1'b0}}, cantidad_buffers};
         DIR_ESTADO: begin
            lectura_registros[BIT_OCUPADO]      = en_solicitud;
            lectura_registros[BIT_ERROR_CONFIG] = error_config;
            lectura_registros[BIT_ABORTADO]     = abortado;
         end
`ifdef SECUENCIADOR_CONTADOR_ESPERAS_EN
         DIR_ESPERAS:  lectura_registros = esperas;
`endif
         default:      lectura_registros = '0;
      endcase
   end

endmodule

// File: tb/tb_secuenciador_lecturas_ventana.sv
// ---------------------------------------------------------------------------
// tb_secuenciador_lecturas_ventana
// Self-checking bench: register map vectors from a table, then sequencer
// runs whose reads are checked against a scoreboard of expected
// {address, buffer} pairs built when each run is started.
// ---------------------------------------------------------------------------
module tb_secuenciador_lecturas_ventana;
   import ventana_pkg::*;

   localparam int W    = 21;
   localparam int WA   = 11;
   localparam int WB   = 3;
   localparam int LPB  = 2;
   localparam int PASO = 1;

   logic          clk;
   logic          reset;
   logic [WA-1:0] direccion_registros;
   logic [W-1:0]  datos_registros;
   logic          habilitacion_registros;
   logic [W-1:0]  lectura_registros;
   logic [W-1:0]  mem_direccion;
   logic          mem_solicitud;
   logic          mem_aceptada;
   logic [WB-1:0] buffer_seleccion;
   logic          ocupado;
   logic          fin;

   secuenciador_lecturas_ventana #(
      .BITS_BUS_DATOS_INSTR(W),
      .BITS_BUS_DIRECCION_INSTR(WA),
      .BITS_BUFFERS(WB),
      .LECTURAS_POR_BUFFER(LPB),
      .PASO_DIRECCION(PASO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .direccion_registros(direccion_registros),
      .datos_registros(datos_registros),
      .habilitacion_registros(habilitacion_registros),
      .lectura_registros(lectura_registros),
      .mem_direccion(mem_direccion),
      .mem_solicitud(mem_solicitud),
      .mem_aceptada(mem_aceptada),
      .buffer_seleccion(buffer_seleccion),
      .ocupado(ocupado),
      .fin(fin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]  direccion;
      logic [WB-1:0] buffer;
   } transfer_t;

   typedef struct {
      logic [WA-1:0] dir;
      logic [W-1:0]  dato;
      logic          escribir;
      logic [W-1:0]  esperado;
   } vector_t;

   transfer_t esperados[$];
   transfer_t t_sb;
   vector_t   vectores[10];

   int errores = 0;
   int comprobaciones = 0;
   int transfers_vistas = 0;
   int fins_vistos = 0;

   task automatic checkOutput(input string nombre, input logic [W-1:0] actual,
                              input logic [W-1:0] requerido);
      comprobaciones++;
      if (actual !== requerido) begin
         errores++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", nombre, actual, requerido);
      end
   endtask

   task automatic applyStimulus(input logic [WA-1:0] dir, input logic [W-1:0] dato);
      @(posedge clk);
      #1;
      direccion_registros    = dir;
      datos_registros        = dato;
      habilitacion_registros = 1'b1;
      @(posedge clk);
      #1;
      habilitacion_registros = 1'b0;
   endtask

   task automatic read_reg(input logic [WA-1:0] dir, output logic [W-1:0] valor);
      direccion_registros = dir;
      #1;
      valor = lectura_registros;
   endtask

   // Reference sequence of one run, pushed when the run is started
   task automatic push_esperados(input logic [W-1:0] inicio, input int n,
                                 input logic [WB-1:0] buffers);
      int lb = 0;
      int bs = 0;
      int eff = (buffers == 0) ? 1 : int'(buffers);
      for (int i = 0; i < n; i++) begin
         transfer_t e;
         e.direccion = inicio + W'(i * PASO);
         e.buffer    = WB'(bs);
         esperados.push_back(e);
         if (lb == LPB - 1) begin
            lb = 0;
            bs = (bs == eff - 1) ? 0 : bs + 1;
         end else begin
            lb++;
         end
      end
   endtask

   task automatic wait_fin(input string nombre, input int limite, output int ciclos);
      ciclos = 0;
      for (int c = 1; c <= limite; c++) begin
         @(negedge clk);
         if (fin) begin
            ciclos = c;
            break;
         end
      end
      if (ciclos == 0) begin
         comprobaciones++;
         errores++;
         $display("[TB] FAIL %s: no fin pulse within %0d cycles", nombre, limite);
      end
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every accepted read must match the head of the queue
   always @(negedge clk) begin
      if (reset && fin) fins_vistos++;
      if (reset && mem_solicitud && mem_aceptada) begin
         transfers_vistas++;
         if (esperados.size() == 0) begin
            comprobaciones++;
            errores++;
            $display("[TB] FAIL sb_unexpected: actual addr=0x%0h required no transfer", mem_direccion);
         end else begin
            t_sb = esperados.pop_front();
            checkOutput("sb_direccion", mem_direccion, t_sb.direccion);
            checkOutput("sb_buffer", W'(buffer_seleccion), W'(t_sb.buffer));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [W-1:0] valor;
      int ciclos;
      int base_transfers;
      int base_fins;

      vectores[0] = '{dir: 11'h000, dato: 21'h00100, escribir: 1'b1, esperado: 21'h00100};
      vectores[1] = '{dir: 11'h001, dato: 21'h1ABCD, escribir: 1'b1, esperado: 21'h1ABCD};
      vectores[2] = '{dir: 11'h002, dato: 21'h0001F, escribir: 1'b1, esperado: 21'h00007};
      vectores[3] = '{dir: 11'h003, dato: 21'h00000, escribir: 1'b1, esperado: 21'h00000};
      vectores[4] = '{dir: 11'h004, dato: 21'h00007, escribir: 1'b1, esperado: 21'h00000};
      vectores[5] = '{dir: 11'h005, dato: 21'h00055, escribir: 1'b1, esperado: 21'h00000};
      vectores[6] = '{dir: 11'h006, dato: 21'h00123, escribir: 1'b1, esperado: 21'h00000};
      vectores[7] = '{dir: 11'h007, dato: 21'h00001, escribir: 1'b1, esperado: 21'h00000};
      vectores[8] = '{dir: 11'h008, dato: 21'h00042, escribir: 1'b1, esperado: 21'h00042};
      vectores[9] = '{dir: 11'h000, dato: 21'h00000, escribir: 1'b0, esperado: 21'h00042};

      reset                  = 1'b0;
      direccion_registros    = '0;
      datos_registros        = '0;
      habilitacion_registros = 1'b0;
      mem_aceptada           = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_solicitud", W'(mem_solicitud), '0);
      checkOutput("reset_direccion", mem_direccion, '0);
      checkOutput("reset_ocupado", W'(ocupado), '0);
      checkOutput("reset_fin", W'(fin), '0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      read_reg(WA'(DIR_ESTADO), valor);
      checkOutput("reset_estado", valor, '0);

      $display("[TB] register map vectors");
      for (int i = 0; i < 10; i++) begin
         if (vectores[i].escribir) applyStimulus(vectores[i].dir, vectores[i].dato);
         read_reg(vectores[i].dir, valor);
         checkOutput($sformatf("regmap_%0d", i), valor, vectores[i].esperado);
      end

      $display("[TB] basic run");
      applyStimulus(WA'(DIR_INICIO), 21'h100);
      applyStimulus(WA'(DIR_LECTURAS), 21'd4);
      applyStimulus(WA'(DIR_BUFFERS), 21'd2);
      push_esperados(21'h100, 4, 3'd2);
      base_transfers = transfers_vistas;
      applyStimulus(WA'(DIR_CONTROL), 21'h1);
      wait_fin("basic_fin", 20, ciclos);
      checkOutput("basic_fin_latency", W'(ciclos), W'(5));
      checkOutput("basic_reads", W'(transfers_vistas - base_transfers), W'(4));
      checkOutput("basic_sb_empty", W'(esperados.size()), '0);

      $display("[TB] backpressure run");
      push_esperados(21'h100, 4, 3'd2);
      base_transfers = transfers_vistas;
      applyStimulus(WA'(DIR_CONTROL), 21'h1);
      ciclos = 0;
      for (int c = 1; c <= 20; c++) begin
         mem_aceptada = !(c >= 2 && c <= 4);
         @(negedge clk);
         if (c >= 2 && c <= 5) checkOutput("bp_addr_held", mem_direccion, 21'h101);
         if (fin) begin
            ciclos = c;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (ciclos == 0) begin
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      mem_aceptada = 1'b1;
      checkOutput("bp_fin_latency", W'(ciclos), W'(8));
      checkOutput("bp_reads", W'(transfers_vistas - base_transfers), W'(4));
      read_reg(WA'(DIR_ESPERAS), valor);
`ifdef SECUENCIADOR_CONTADOR_ESPERAS_EN
      checkOutput("bp_wait_count", valor, W'(3));
`else
      checkOutput("bp_wait_count", valor, '0);
`endif

      $display("[TB] zero length run");
      applyStimulus(WA'(DIR_LECTURAS), 21'd0);
      base_transfers = transfers_vistas;
      applyStimulus(WA'(DIR_CONTROL), 21'h1);
      @(negedge clk);
      checkOutput("zero_fin", W'(fin), W'(1));
      checkOutput("zero_solicitud", W'(mem_solicitud), '0);
      @(negedge clk);
      checkOutput("zero_fin_single", W'(fin), '0);
      checkOutput("zero_reads", W'(transfers_vistas - base_transfers), '0);
      @(posedge clk);
      #1;

      $display("[TB] busy protection and abort");
      mem_aceptada = 1'b0;
      applyStimulus(WA'(DIR_INICIO), 21'h200);
      applyStimulus(WA'(DIR_LECTURAS), 21'd100);
      applyStimulus(WA'(DIR_BUFFERS), 21'd1);
      applyStimulus(WA'(DIR_CONTROL), 21'h1);
      base_fins = fins_vistos;
      applyStimulus(WA'(DIR_INICIO), 21'h55);
      read_reg(WA'(DIR_ESTADO), valor);
      checkOutput("busy_estado", valor, 21'b011);
      read_reg(WA'(DIR_INICIO), valor);
      checkOutput("busy_inicio_kept", valor, 21'h200);
      applyStimulus(WA'(DIR_CONTROL), 21'h2);
      read_reg(WA'(DIR_ESTADO), valor);
      checkOutput("abort_estado", valor, 21'b110);
      checkOutput("abort_solicitud", W'(mem_solicitud), '0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("abort_no_fin", W'(fins_vistos - base_fins), '0);
      mem_aceptada = 1'b1;

      $display("[TB] address wrap-around");
      applyStimulus(WA'(DIR_INICIO), 21'h1FFFFE);
      applyStimulus(WA'(DIR_LECTURAS), 21'd4);
      applyStimulus(WA'(DIR_BUFFERS), 21'd0);
      push_esperados(21'h1FFFFE, 4, 3'd0);
      applyStimulus(WA'(DIR_CONTROL), 21'h1);
      read_reg(WA'(DIR_ESTADO), valor);
      checkOutput("wrap_estado_cleared", valor, 21'b001);
      wait_fin("wrap_fin", 20, ciclos);
      checkOutput("wrap_sb_empty", W'(esperados.size()), '0);

      $display("[TB] reset during run");
      mem_aceptada = 1'b0;
      applyStimulus(WA'(DIR_INICIO), 21'h300);
      applyStimulus(WA'(DIR_LECTURAS), 21'd10);
      applyStimulus(WA'(DIR_BUFFERS), 21'd3);
      applyStimulus(WA'(DIR_CONTROL), 21'h1);
      checkOutput("prereset_solicitud", W'(mem_solicitud), W'(1));
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midreset_solicitud", W'(mem_solicitud), '0);
      checkOutput("midreset_ocupado", W'(ocupado), '0);
      checkOutput("midreset_direccion", mem_direccion, '0);
      read_reg(WA'(DIR_INICIO), valor);
      checkOutput("midreset_inicio", valor, '0);
      read_reg(WA'(DIR_LECTURAS), valor);
      checkOutput("midreset_lecturas", valor, '0);
      read_reg(WA'(DIR_BUFFERS), valor);
      checkOutput("midreset_buffers", valor, '0);
      @(posedge clk);
      #1;
      reset        = 1'b1;
      mem_aceptada = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("postreset_solicitud", W'(mem_solicitud), '0);

      $display("Result: errors=%0d of %0d checks", errores, comprobaciones);
      $finish;
   end

endmodule
